addr_walk_array: RTL

Multi-unit address generator for the systolic compute array; second-generation replacement for the flat per-unit pointer block. A configuration is latched through a valid/ready handshake. Each active unit then gets a compacted base address and walks a 2-D (rows × cols, row-strided) window in lockstep on `step`. The block also reports per-unit bias addresses, `last`, and a `done` pulse. It sits between the layer sequencer, which issues configs and steps, and the weight/bias memory read ports.

---
 rtl/addr_walk_pkg.sv | 22 ++
 rtl/addr_walk_array_rank_compactor.sv | 25 ++
 rtl/addr_walk_array.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/addr_walk_pkg.sv
// Shared types and helpers for the multi-unit 2-D address walker.
package addr_walk_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } walk_state_t;

    // Rank width is sized for the largest array this block is built for,
    // so any N_UNITS up to N_UNITS_MAX shares one rank type.
    localparam int N_UNITS_MAX = 64;
    localparam int RANK_W      = $clog2(N_UNITS_MAX + 1);

    function automatic logic [RANK_W-1:0] popcount(input logic [N_UNITS_MAX-1:0] v);
        logic [RANK_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_UNITS_MAX; i++)
            c = c + RANK_W'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/addr_walk_array_rank_compactor.sv
// Prefix popcount over the active mask: each unit's compacted rank plus the total.
module rank_compactor
    import addr_walk_pkg::*;
#(
    parameter int N_UNITS = 16
) (
    input  logic [N_UNITS-1:0]             active,
    output logic [N_UNITS-1:0][RANK_W-1:0] rank,
    output logic [RANK_W-1:0]              n_act
);

    logic [RANK_W-1:0] acc;

    always_comb begin
        acc  = '0;
        rank = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            rank[i] = acc;
            acc     = acc + RANK_W'(active[i]);
        end
    end

    assign n_act = popcount(N_UNITS_MAX'(active));

endmodule

// File: rtl/addr_walk_array.sv
// Multi-unit address generator: latches a config, then walks a row-strided
// 2-D window in lockstep for every active unit, with rank-compacted bases.
module addr_walk_array
    import addr_walk_pkg::*;
#(
    parameter int N_UNITS = 16,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [ADDR_W-1:0]               cfg_start_addr,
    input  logic [ADDR_W-1:0]               cfg_unit_stride,
    input  logic [DIM_W-1:0]                cfg_rows,
    input  logic [DIM_W-1:0]                cfg_cols,
    input  logic [ADDR_W-1:0]               cfg_row_stride,
    input  logic [N_UNITS-1:0]              cfg_active,
    input  logic                            abort,
    input  logic                            step,
    output logic                            addr_valid,
    output logic [N_UNITS-1:0][ADDR_W-1:0]  addr_out,
    output logic [N_UNITS-1:0][ADDR_W-1:0]  bias_addr,
    output logic                            last,
    output logic                            done,
    output logic                            busy
);

    walk_state_t state_q, state_d;

    logic [DIM_W-1:0]   rows_q, cols_q, row_q, col_q;
    logic [ADDR_W-1:0]  row_stride_q, offset_q, row_off_q, row_off_nxt;
    logic [N_UNITS-1:0] active_q;
    logic               done_q, done_d;
    logic               accept, degenerate, load, adv_col, adv_row;
    logic               row_end, col_end;

    logic [N_UNITS-1:0][RANK_W-1:0] rank;
    logic [RANK_W-1:0]              n_act;
    logic [ADDR_W-1:0]              bias_base;

    rank_compactor #(.N_UNITS(N_UNITS)) u_rank (
        .active (cfg_active),
        .rank   (rank),
        .n_act  (n_act)
    );

    assign cfg_ready   = (state_q == S_IDLE) && !rst;
    assign accept      = cfg_valid && cfg_ready;
    assign degenerate  = (cfg_rows == '0) || (cfg_cols == '0) || (n_act == '0);
    assign bias_base   = cfg_start_addr + ADDR_W'(n_act) * cfg_unit_stride;

    assign row_end     = (row_q == rows_q - DIM_W'(1));
    assign col_end     = (col_q == cols_q - DIM_W'(1));
    assign row_off_nxt = row_off_q + row_stride_q;

    assign addr_valid  = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign last        = addr_valid && row_end && col_end;
    assign done        = done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        adv_col = 1'b0;
        adv_row = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    // An empty window or no active units completes immediately.
                    if (degenerate) done_d  = 1'b1;
                    else            state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    if (!col_end)      adv_col = 1'b1;
                    else if (!row_end) adv_row = 1'b1;
                    else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            rows_q       <= '0;
            cols_q       <= '0;
            row_stride_q <= '0;
            active_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            offset_q     <= '0;
            row_off_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                rows_q       <= cfg_rows;
                cols_q       <= cfg_cols;
                row_stride_q <= cfg_row_stride;
                active_q     <= cfg_active;
                row_q        <= '0;
                col_q        <= '0;
                offset_q     <= '0;
                row_off_q    <= '0;
            end else if (adv_col) begin
                col_q    <= col_q + DIM_W'(1);
                offset_q <= offset_q + ADDR_W'(1);
            end else if (adv_row) begin
                col_q     <= '0;
                row_q     <= row_q + DIM_W'(1);
                row_off_q <= row_off_nxt;
                offset_q  <= row_off_nxt;
            end
        end
    end

    for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
        logic [ADDR_W-1:0] base_q, bias_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                base_q <= '0;
                bias_q <= '0;
            end else if (load) begin
                base_q <= cfg_start_addr + ADDR_W'(rank[i]) * cfg_unit_stride;
                bias_q <= cfg_active[i] ? bias_base + ADDR_W'(rank[i]) : '0;
            end
        end

        assign addr_out[i]  = (addr_valid && active_q[i]) ? base_q + offset_q : '0;
        assign bias_addr[i] = bias_q;
    end

endmodule
